mram_serial_host_if: RTL and testbench
======================================

// Module: mram_serial_host_if
// PURPOSE
//  Host-side initiator for the serial MRAM/burst-controller interface. Takes parallel
//  commands (op, mode, addr, burst length) plus write-data beats over valid/ready, and
//  serializes them onto burst_len_in/addr_in/data_in with burst_en/mode_sel/read_write_sel.
//  For reads it deserializes ser_data_out into parallel rdata beats. Sits between
//  test/CPU logic and the integrated burst+MRAM top.
// PARAMETERS
//  ADDR_W    8       serial address field width (bits)
//  DATA_W    8       data word width per beat (bits)
//  LEN_W     4       serial burst-length field width (bits)
//  RD_LAT    2       cycles from end of address field to first ser_data_out bit (>=1)
//  RW_IDLE   3'b000  read_write_sel code when idle or waiting
//  RW_WRITE  3'b001  read_write_sel code while shifting write data
//  RW_READ   3'b010  read_write_sel code during read latency and read capture
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  cmd_valid      in   1       command present
//  cmd_ready      out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write      in   1       1 = write, 0 = read
//  cmd_burst      in   1       1 = burst mode, 0 = single transfer
//  cmd_addr       in   ADDR_W  start address
//  cmd_len        in   LEN_W   burst beat count (ignored when cmd_burst=0)
//  wdata          in   DATA_W  write beat
//  wdata_valid    in   1       write beat present
//  wdata_ready    out  1       write beat accepted on wdata_valid & wdata_ready
//  rdata          out  DATA_W  captured read beat
//  rdata_valid    out  1       1-cycle pulse, rdata valid
//  busy           out  1       high from cycle after accept through DONE
//  done           out  1       1-cycle pulse at end of transaction
//  burst_en       out  1       to burst controller enable
//  mode_sel       out  1       0 single, 1 burst
//  burst_len_in   out  1       serial burst length, MSB first
//  addr_in        out  1       serial address, MSB first
//  data_in        out  1       serial write data, MSB first
//  read_write_sel out  3       MRAM operation select
//  ser_data_out   in   1       serial read data from MRAM, MSB first
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (read_write_sel=RW_IDLE), except cmd_ready=1.
//  States: IDLE, LEN, ADDR, WWAIT, WDATA, RLAT, RDATA, DONE. One serial bit per clk.
//  IDLE: cmd_ready=1. On accept latch cmd; next state LEN if cmd_burst else ADDR.
//   beats = cmd_burst ? max(cmd_len,1) : 1. cmd_len=0 still sent as 0 on the line.
//  burst_en=1 and mode_sel=latched cmd_burst in every state except IDLE and DONE.
//  LEN: LEN_W cycles, burst_len_in = cmd_len[LEN_W-1..0]; then ADDR.
//  ADDR: ADDR_W cycles, addr_in = cmd_addr MSB first; then WWAIT (write) or RLAT (read).
//  Idle serial lines (outside their field) drive 0.
//  WWAIT: wdata_ready=1, read_write_sel=RW_IDLE; on handshake load shift reg -> WDATA.
//   Stalls indefinitely while wdata_valid=0.
//  WDATA: DATA_W cycles, data_in = beat MSB first, read_write_sel=RW_WRITE.
//   After last bit: beats remaining ? WWAIT : DONE.
//  RLAT: RD_LAT cycles, read_write_sel=RW_READ; first beat only -> RDATA.
//  RDATA: DATA_W cycles sampling ser_data_out MSB first, read_write_sel=RW_READ.
//   Cycle after last sample: rdata updated, rdata_valid=1; next beat's RDATA starts that
//   same cycle (back-to-back, no gap); after final beat -> DONE.
//  DONE: 1 cycle, done=1, busy=1, burst_en=0, read_write_sel=RW_IDLE; then IDLE.
//  Latency (defaults, single write, wdata ready, accept at cycle 0): ADDR 1-8, WWAIT 9,
//   WDATA 10-17, DONE 18, cmd_ready high again 19.
//  cmd_valid while busy ignored (cmd_ready=0). Beat counter LEN_W bits, no wrap.
//  rst mid-transaction: abort at next edge, all outputs to reset values, no done,
//   no rdata_valid for partial beat.
// TESTING
//  Single write addr=0xA5 data=0x3C -> addr_in 10100101 cycles 1-8, data_in 00111100
//   cycles 10-17 with RW_WRITE, done at 18, burst_len_in stays 0.
//  Burst write len=3, data 0x01,0x02,0x03, wdata_valid dropped 4 cycles before beat 2
//   -> burst_len_in 0011, three WDATA frames, RW_IDLE and lines 0 during stall, one done.
//  Single read, model drives 0x96 after RD_LAT -> rdata=0x96 with one rdata_valid pulse.
//  Burst read len=4, model streams 0x11,0x22,0x33,0x44 -> four rdata_valid pulses
//   exactly DATA_W cycles apart, correct order, done after the 4th.
//  Burst len=0 -> length field 0000 sent, exactly one beat performed.
//  rst asserted mid-WDATA and mid-RDATA -> next cycle IDLE, all outputs 0, cmd_ready=1,
//   no done/rdata_valid; a following single write completes normally.

Source files
------------

// File: rtl/mram_serial_host_if.sv
// rtl/mram_serial_host_if.sv - host-side serial initiator for the burst/MRAM interface
//
// Accepts parallel commands and write beats over valid/ready, shifts the length,
// address and write-data fields out one bit per clock (MSB first), and gathers
// serial read data back into parallel beats.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (write, burst, addr, len)
//   wdata/wdata_valid/wdata_ready write beat handshake
//   rdata/rdata_valid             captured read beat, one-cycle valid pulse
//   busy, done                    transaction in flight, end-of-transaction pulse
//   burst_en, mode_sel            burst controller enable and single/burst select
//   burst_len_in, addr_in,
//   data_in                       serial output fields, MSB first
//   read_write_sel                MRAM operation code
//   ser_data_out                  serial read data from the MRAM, MSB first
module mram_serial_host_if #(
   parameter int         ADDR_W   = 8,
   parameter int         DATA_W   = 8,
   parameter int         LEN_W    = 4,
   parameter int         RD_LAT   = 2,
   parameter logic [2:0] RW_IDLE  = 3'b000,
   parameter logic [2:0] RW_WRITE = 3'b001,
   parameter logic [2:0] RW_READ  = 3'b010
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic              cmd_burst,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              busy,
   output logic              done,
   output logic              burst_en,
   output logic              mode_sel,
   output logic              burst_len_in,
   output logic              addr_in,
   output logic              data_in,
   output logic [2:0]        read_write_sel,
   input  logic              ser_data_out
);

   localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int MAX_LL = (LEN_W > RD_LAT) ? LEN_W : RD_LAT;
   localparam int MAX_F  = (MAX_AD > MAX_LL) ? MAX_AD : MAX_LL;
   localparam int CNT_W  = $clog2(MAX_F + 1);

   localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_ADDR, S_WWAIT, S_WDATA, S_RLAT, S_RDATA, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  beats_q, beats_d;
   logic              write_q, write_d;
   logic              burst_q, burst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   // Output shift registers: the MSB is the serial line, and each register is
   // empty (all zero) once its field has been shifted out, so lines idle at 0.
   logic [LEN_W-1:0]  len_sh_q, len_sh_d;
   logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
   logic [DATA_W-1:0] wsh_q, wsh_d;
   logic [DATA_W-2:0] rsh_q, rsh_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              wdata_ready_q, wdata_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              burst_en_q, burst_en_d;
   logic              mode_sel_q, mode_sel_d;
   logic [2:0]        rw_sel_q, rw_sel_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      beats_d       = beats_q;
      write_d       = write_q;
      burst_d       = burst_q;
      addr_d        = addr_q;
      len_sh_d      = len_sh_q;
      addr_sh_d     = addr_sh_q;
      wsh_d         = wsh_q;
      rsh_d         = rsh_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               write_d = cmd_write;
               burst_d = cmd_burst;
               addr_d  = cmd_addr;
               cnt_d   = '0;
               // A zero-length burst still performs one beat.
               beats_d = (cmd_burst && cmd_len != '0) ? cmd_len : LEN_W'(1);
               if (cmd_burst) begin
                  state_d  = S_LEN;
                  len_sh_d = cmd_len;
               end else begin
                  state_d   = S_ADDR;
                  addr_sh_d = cmd_addr;
               end
            end
         end
         S_LEN: begin
            len_sh_d = len_sh_q << 1;
            if (cnt_q == LEN_LAST) begin
               cnt_d     = '0;
               state_d   = S_ADDR;
               addr_sh_d = addr_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ADDR: begin
            addr_sh_d = addr_sh_q << 1;
            if (cnt_q == ADDR_LAST) begin
               cnt_d   = '0;
               state_d = write_q ? S_WWAIT : S_RLAT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WWAIT: begin
            if (wdata_valid) begin
               wsh_d   = wdata;
               state_d = S_WDATA;
            end
         end
         S_WDATA: begin
            wsh_d = wsh_q << 1;
            if (cnt_q == DATA_LAST) begin
               cnt_d   = '0;
               beats_d = beats_q - LEN_W'(1);
               state_d = (beats_q == LEN_W'(1)) ? S_DONE : S_WWAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RLAT: begin
            if (cnt_q == LAT_LAST) begin
               cnt_d   = '0;
               state_d = S_RDATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RDATA: begin
            rsh_d = (DATA_W-1)'({rsh_q, ser_data_out});
            if (cnt_q == DATA_LAST) begin
               // Beat completes; the next beat (if any) starts sampling at once.
               rdata_d       = {rsh_q, ser_data_out};
               rdata_valid_d = 1'b1;
               cnt_d         = '0;
               beats_d       = beats_q - LEN_W'(1);
               state_d       = (beats_q == LEN_W'(1)) ? S_DONE : S_RDATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Control outputs are registered from the next state so they line up
      // with the state they describe.
      cmd_ready_d   = (state_d == S_IDLE);
      wdata_ready_d = (state_d == S_WWAIT);
      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      burst_en_d    = (state_d != S_IDLE) && (state_d != S_DONE);
      mode_sel_d    = burst_en_d && burst_d;
      if (state_d == S_WDATA)
         rw_sel_d = RW_WRITE;
      else if (state_d == S_RLAT || state_d == S_RDATA)
         rw_sel_d = RW_READ;
      else
         rw_sel_d = RW_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         beats_q       <= '0;
         write_q       <= 1'b0;
         burst_q       <= 1'b0;
         addr_q        <= '0;
         len_sh_q      <= '0;
         addr_sh_q     <= '0;
         wsh_q         <= '0;
         rsh_q         <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         cmd_ready_q   <= 1'b1;
         wdata_ready_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         burst_en_q    <= 1'b0;
         mode_sel_q    <= 1'b0;
         rw_sel_q      <= RW_IDLE;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         beats_q       <= beats_d;
         write_q       <= write_d;
         burst_q       <= burst_d;
         addr_q        <= addr_d;
         len_sh_q      <= len_sh_d;
         addr_sh_q     <= addr_sh_d;
         wsh_q         <= wsh_d;
         rsh_q         <= rsh_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         cmd_ready_q   <= cmd_ready_d;
         wdata_ready_q <= wdata_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         burst_en_q    <= burst_en_d;
         mode_sel_q    <= mode_sel_d;
         rw_sel_q      <= rw_sel_d;
      end
   end

   assign cmd_ready      = cmd_ready_q;
   assign wdata_ready    = wdata_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign burst_en       = burst_en_q;
   assign mode_sel       = mode_sel_q;
   assign burst_len_in   = len_sh_q[LEN_W-1];
   assign addr_in        = addr_sh_q[ADDR_W-1];
   assign data_in        = wsh_q[DATA_W-1];
   assign read_write_sel = rw_sel_q;
   assign rdata          = rdata_q;
   assign rdata_valid    = rdata_valid_q;

endmodule

// File: tb/tb_mram_serial_host_if.sv
// tb/tb_mram_serial_host_if.sv - self-checking bench for mram_serial_host_if
module tb_mram_serial_host_if;

   localparam logic [2:0] RWI = 3'b000;
   localparam logic [2:0] RWW = 3'b001;
   localparam logic [2:0] RWR = 3'b010;
   localparam int         RD_LAT = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, cmd_write, cmd_burst;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic [7:0] wdata;
   logic       wdata_valid, wdata_ready;
   logic [7:0] rdata;
   logic       rdata_valid, busy, done, burst_en, mode_sel;
   logic       burst_len_in, addr_in, data_in;
   logic [2:0] read_write_sel;
   logic       ser_data_out;

   always #5 clk = ~clk;

   mram_serial_host_if #(
      .ADDR_W(8), .DATA_W(8), .LEN_W(4), .RD_LAT(RD_LAT),
      .RW_IDLE(RWI), .RW_WRITE(RWW), .RW_READ(RWR)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
      .burst_en(burst_en), .mode_sel(mode_sel), .burst_len_in(burst_len_in),
      .addr_in(addr_in), .data_in(data_in), .read_write_sel(read_write_sel),
      .ser_data_out(ser_data_out)
   );

   // Output vector layout:
   // [20] cmd_ready [19] wdata_ready [18] busy [17] done [16] burst_en
   // [15] mode_sel [14] burst_len_in [13] addr_in [12] data_in
   // [11:9] read_write_sel [8] rdata_valid [7:0] rdata
   typedef struct packed {
      logic        cv;
      logic        wv;
      logic [7:0]  wd;
      logic        ser;
      logic [20:0] o;
   } cyc_t;

   cyc_t        tq[$];
   logic [7:0]  m_rdata;
   logic [7:0]  bdat[16];
   int          bstall[16];
   logic        t_wr, t_burst, hold_cv;
   logic [7:0]  t_addr;
   logic [3:0]  t_len;

   int          checks = 0;
   int          errors = 0;
   logic        chk_on = 1'b0;
   logic [20:0] exp_o;
   int          cyc_idx;
   int          done_cnt, done_at;
   int          rv_at[$];
   logic [7:0]  rv_dat[$];

   function automatic logic [20:0] outv(logic cr, logic wr, logic bz, logic dn,
                                        logic be, logic ms, logic lb, logic ab,
                                        logic db, logic [2:0] rw, logic rv,
                                        logic [7:0] rd);
      return {cr, wr, bz, dn, be, ms, lb, ab, db, rw, rv, rd};
   endfunction

   function automatic cyc_t bcyc(logic wrdy, logic lb, logic ab, logic db,
                                 logic [2:0] rw, logic wv, logic [7:0] wd,
                                 logic ser, logic rv);
      cyc_t c;
      c.cv  = hold_cv;
      c.wv  = wv;
      c.wd  = wd;
      c.ser = ser;
      c.o   = outv(1'b0, wrdy, 1'b1, 1'b0, 1'b1, t_burst, lb, ab, db, rw, rv, m_rdata);
      return c;
   endfunction

   // Expected cycle-by-cycle trace of one transaction, from accept cycle to
   // the first idle cycle afterwards, built from the field/phase rules.
   task automatic gen();
      cyc_t c;
      int   nb;
      logic rv;
      tq.delete();
      nb = (t_burst && t_len != 4'd0) ? int'(t_len) : 1;
      c = '0;
      c.cv = 1'b1;
      c.o  = outv(1, 0, 0, 0, 0, 0, 0, 0, 0, RWI, 0, m_rdata);
      tq.push_back(c);
      if (t_burst)
         for (int i = 0; i < 4; i++) tq.push_back(bcyc(0, t_len[3-i], 0, 0, RWI, 0, 8'h00, 0, 0));
      for (int i = 0; i < 8; i++) tq.push_back(bcyc(0, 0, t_addr[7-i], 0, RWI, 0, 8'h00, 0, 0));
      if (t_wr) begin
         for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < bstall[b]; s++) tq.push_back(bcyc(1, 0, 0, 0, RWI, 0, 8'hFF, 0, 0));
            tq.push_back(bcyc(1, 0, 0, 0, RWI, 1, bdat[b], 0, 0));
            for (int i = 0; i < 8; i++) tq.push_back(bcyc(0, 0, 0, bdat[b][7-i], RWW, 0, 8'h00, 0, 0));
         end
      end else begin
         for (int i = 0; i < RD_LAT; i++) tq.push_back(bcyc(0, 0, 0, 0, RWR, 0, 8'h00, 0, 0));
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 8; i++) begin
               rv = 1'b0;
               if (i == 0 && b > 0) begin
                  m_rdata = bdat[b-1];
                  rv = 1'b1;
               end
               tq.push_back(bcyc(0, 0, 0, 0, RWR, 0, 8'h00, bdat[b][7-i], rv));
            end
         end
         m_rdata = bdat[nb-1];
      end
      c = '0;
      c.cv = hold_cv;
      c.o  = outv(0, 0, 1, 1, 0, 0, 0, 0, 0, RWI, !t_wr, m_rdata);
      tq.push_back(c);
      c = '0;
      c.o = outv(1, 0, 0, 0, 0, 0, 0, 0, 0, RWI, 0, m_rdata);
      tq.push_back(c);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clr();
      done_cnt = 0;
      done_at  = -1;
      rv_at.delete();
      rv_dat.delete();
   endtask

   task automatic set_cmd(input logic wr, input logic bu, input logic [7:0] ad,
                          input logic [3:0] ln, input logic hc);
      t_wr = wr; t_burst = bu; t_addr = ad; t_len = ln; hold_cv = hc;
      cmd_write = wr; cmd_burst = bu; cmd_addr = ad; cmd_len = ln;
   endtask

   // Plays the trace; abort_at >= 0 pulses rst during that trace cycle.
   task automatic run(input int abort_at);
      cyc_t cur;
      for (int k = 0; k < tq.size(); k++) begin
         @(posedge clk);
         #1;
         cur          = tq[k];
         cmd_valid    = cur.cv;
         wdata_valid  = cur.wv;
         wdata        = cur.wd;
         ser_data_out = cur.ser;
         exp_o        = cur.o;
         cyc_idx      = k;
         chk_on       = 1'b1;
         if (k == abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst          = 1'b0;
            cmd_valid    = 1'b0;
            wdata_valid  = 1'b0;
            ser_data_out = 1'b0;
            m_rdata      = 8'h00;
            exp_o        = outv(1, 0, 0, 0, 0, 0, 0, 0, 0, RWI, 0, 8'h00);
            cyc_idx      = -1;
            return;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         logic [20:0] act;
         act = {cmd_ready, wdata_ready, busy, done, burst_en, mode_sel,
                burst_len_in, addr_in, data_in, read_write_sel, rdata_valid, rdata};
         checks++;
         if (act !== exp_o) begin
            errors++;
            $display("FAIL trace cyc %0d: outputs got %h expected %h", cyc_idx, act, exp_o);
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_at = cyc_idx;
         end
         if (rdata_valid === 1'b1) begin
            rv_at.push_back(cyc_idx);
            rv_dat.push_back(rdata);
         end
      end
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 0; wdata_valid = 0; wdata = 0; ser_data_out = 0;
      set_cmd(0, 0, 8'h00, 4'h0, 0);
      m_rdata = 8'h00;
      for (int i = 0; i < 16; i++) begin bdat[i] = 8'h00; bstall[i] = 0; end
      repeat (3) @(posedge clk);
      #1;
      exp_o   = outv(1, 0, 0, 0, 0, 0, 0, 0, 0, RWI, 0, 8'h00);
      cyc_idx = -1;
      chk_on  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single write A5/3C; cmd_len nonzero but must not appear on the line.
      set_cmd(1, 0, 8'hA5, 4'h7, 0);
      bdat[0] = 8'h3C; bstall[0] = 0;
      gen();
      chk("pin_sw_len", tq.size(), 20);
      chk("pin_sw_addr_msb", int'(tq[1].o[13]), 1);
      chk("pin_sw_data_b7", int'(tq[10].o[12]), 0);
      chk("pin_sw_data_b5", int'(tq[12].o[12]), 1);
      chk("pin_sw_done18", int'(tq[18].o[17]), 1);
      clr();
      run(-1);
      chk("sw_done_at", done_at, 18);
      chk("sw_done_cnt", done_cnt, 1);

      // Burst write len 3, beat 2 stalled 4 cycles, cmd_valid held while busy.
      set_cmd(1, 1, 8'h5C, 4'd3, 1);
      bdat[0] = 8'h01; bdat[1] = 8'h02; bdat[2] = 8'h03;
      bstall[0] = 0; bstall[1] = 4; bstall[2] = 0;
      gen();
      chk("pin_bw_len", tq.size(), 46);
      chk("pin_bw_lenbit", int'(tq[3].o[14]), 1);
      clr();
      run(-1);
      chk("bw_done_cnt", done_cnt, 1);
      chk("bw_done_at", done_at, 44);
      for (int i = 0; i < 16; i++) bstall[i] = 0;

      // Single read returning 0x96.
      set_cmd(0, 0, 8'h3A, 4'h0, 0);
      bdat[0] = 8'h96;
      gen();
      chk("pin_sr_len", tq.size(), 21);
      clr();
      run(-1);
      chk("sr_rv_cnt", rv_dat.size(), 1);
      if (rv_dat.size() > 0) chk("sr_rdata", int'(rv_dat[0]), 8'h96);
      chk("sr_done_at", done_at, 19);

      // Burst read len 4.
      set_cmd(0, 1, 8'hC1, 4'd4, 0);
      bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;
      gen();
      clr();
      run(-1);
      chk("br_rv_cnt", rv_dat.size(), 4);
      if (rv_at.size() > 0) chk("br_rv0_at", rv_at[0], 23);
      for (int i = 0; i < rv_dat.size() && i < 4; i++)
         chk($sformatf("br_rdata%0d", i), int'(rv_dat[i]), 17 * 2 * (i + 1) / 2 * 1 + 0);
      for (int i = 1; i < rv_at.size(); i++)
         chk($sformatf("br_gap%0d", i), rv_at[i] - rv_at[i-1], 8);
      chk("br_done_at", done_at, 47);

      // Burst write with len 0: field 0000, exactly one beat.
      set_cmd(1, 1, 8'h0F, 4'd0, 0);
      bdat[0] = 8'h5A;
      gen();
      chk("pin_b0_len", tq.size(), 24);
      clr();
      run(-1);
      chk("b0_done_cnt", done_cnt, 1);
      chk("b0_done_at", done_at, 22);

      // Reset mid-WDATA, then a normal single write.
      set_cmd(1, 0, 8'h33, 4'h0, 0);
      bdat[0] = 8'hC3;
      gen();
      clr();
      run(12);
      chk("rw_abort_done", done_cnt, 0);
      set_cmd(1, 0, 8'h81, 4'h0, 0);
      bdat[0] = 8'h7E;
      gen();
      clr();
      run(-1);
      chk("rw_after_done", done_cnt, 1);

      // Reset mid-RDATA of beat 2 of a burst read, then a normal single write.
      set_cmd(0, 1, 8'h44, 4'd2, 0);
      bdat[0] = 8'hAA; bdat[1] = 8'h55;
      gen();
      clr();
      run(27);
      chk("rr_abort_done", done_cnt, 0);
      chk("rr_abort_rv", rv_dat.size(), 1);
      set_cmd(1, 0, 8'hE7, 4'h0, 0);
      bdat[0] = 8'h18;
      gen();
      clr();
      run(-1);
      chk("rr_after_done", done_cnt, 1);
      chk("rr_after_done_at", done_at, 18);

      @(posedge clk);
      #1;
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
